// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode.
// Each fetch group's valid slots are packed in program order into storage.
// Decode sees up to DECODE_WIDTH of the oldest entries in each cycle.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   flush_i           drops all buffered and incoming instructions
//   fe_*              fetch group input and the ready handshake
//   de_*              decode window output and the consume handshake
module instr_buffer #(
    parameter int unsigned INSTR_PER_FETCH = 4,
    parameter int unsigned DECODE_WIDTH    = 4,
    parameter int unsigned ILEN            = 32,
    parameter int unsigned PLEN            = 32,
    parameter int unsigned DEPTH           = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            fe_valid_i,
    output logic                            fe_ready_o,
    input  logic [INSTR_PER_FETCH*ILEN-1:0] fe_data_i,
    input  logic [PLEN-1:0]                 fe_pc_i,
    input  logic [INSTR_PER_FETCH-1:0]      fe_slot_valid_i,
    input  logic [INSTR_PER_FETCH*PLEN-1:0] fe_pred_npc_i,
    output logic [DECODE_WIDTH-1:0]         de_valid_o,
    input  logic                            de_ready_i,
    output logic [DECODE_WIDTH*ILEN-1:0]    de_instr_o,
    output logic [DECODE_WIDTH*PLEN-1:0]    de_pc_o,
    output logic [DECODE_WIDTH*PLEN-1:0]    de_pred_npc_o
);

    localparam int unsigned IPF = INSTR_PER_FETCH;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - IPF);
    localparam logic [CW-1:0] DW_CNT    = CW'(DECODE_WIDTH);

    // Storage is not reset; only the pointers and the count are reset.
    logic [ILEN-1:0] instr_q [DEPTH];
    logic [PLEN-1:0] pc_q    [DEPTH];
    logic [PLEN-1:0] npc_q   [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] deq_n;
    logic [PW-1:0] slot_off [IPF];

    // The ready flag depends only on the registered count, so there is no path from de_ready_i.
    assign fe_ready_o = (count_q <= READY_MAX);
    assign enq        = fe_valid_i & fe_ready_o & ~flush_i;

    // Compaction offsets: each valid slot lands after the valid slots that precede it.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < int'(IPF); i++) begin
            slot_off[i] = PW'(enq_n);
            enq_n       = enq_n + CW'(fe_slot_valid_i[i]);
        end
        if (!enq) begin
            enq_n = '0;
        end
    end

    // The pop count is min(count, DECODE_WIDTH). It is zero when decode is not ready or a flush is active.
    always_comb begin
        deq_n = '0;
        if (de_ready_i && !flush_i) begin
            deq_n = (count_q > DW_CNT) ? DW_CNT : count_q;
        end
    end

    // Next-state pointers and count; a flush overrides all other updates.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(deq_n);
        wr_ptr_d = wr_ptr_q + PW'(enq_n);
        count_d  = count_q + enq_n - deq_n;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write for the valid slots of an accepted group
    always_ff @(posedge clk_i) begin
        if (enq) begin
            for (int i = 0; i < int'(IPF); i++) begin
                if (fe_slot_valid_i[i]) begin
                    instr_q[wr_ptr_q + slot_off[i]] <= fe_data_i[i*ILEN +: ILEN];
                    pc_q[wr_ptr_q + slot_off[i]]    <= fe_pc_i + PLEN'(4 * i);
                    npc_q[wr_ptr_q + slot_off[i]]   <= fe_pred_npc_i[i*PLEN +: PLEN];
                end
            end
        end
    end

    // Decode window holds the oldest entries; empty slots drive zero.
    always_comb begin
        de_valid_o    = '0;
        de_instr_o    = '0;
        de_pc_o       = '0;
        de_pred_npc_o = '0;
        for (int k = 0; k < int'(DECODE_WIDTH); k++) begin
            if (CW'(k) < count_q) begin
                de_valid_o[k]                 = 1'b1;
                de_instr_o[k*ILEN +: ILEN]    = instr_q[rd_ptr_q + PW'(k)];
                de_pc_o[k*PLEN +: PLEN]       = pc_q[rd_ptr_q + PW'(k)];
                de_pred_npc_o[k*PLEN +: PLEN] = npc_q[rd_ptr_q + PW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer. A queue-based reference model is checked against the DUT every cycle.
module tb_instr_buffer;

    localparam int IPF = 4;
    localparam int DW  = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } entry_t;

    logic         clk;
    logic         rst_ni;
    logic         flush_i;
    logic         fe_valid_i;
    logic         fe_ready_o;
    logic [127:0] fe_data_i;
    logic [31:0]  fe_pc_i;
    logic [3:0]   fe_slot_valid_i;
    logic [127:0] fe_pred_npc_i;
    logic [3:0]   de_valid_o;
    logic         de_ready_i;
    logic [127:0] de_instr_o;
    logic [127:0] de_pc_o;
    logic [127:0] de_pred_npc_o;

    int checks = 0;
    int errors = 0;
    entry_t q[$];

    instr_buffer dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .fe_valid_i     (fe_valid_i),
        .fe_ready_o     (fe_ready_o),
        .fe_data_i      (fe_data_i),
        .fe_pc_i        (fe_pc_i),
        .fe_slot_valid_i(fe_slot_valid_i),
        .fe_pred_npc_i  (fe_pred_npc_i),
        .de_valid_o     (de_valid_o),
        .de_ready_i     (de_ready_i),
        .de_instr_o     (de_instr_o),
        .de_pc_o        (de_pc_o),
        .de_pred_npc_o  (de_pred_npc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a new group with random data and predicted next-PCs.
    task automatic set_group(input logic [31:0] pc, input logic [3:0] sv);
        fe_pc_i = pc;
        fe_slot_valid_i = sv;
        for (int i = 0; i < IPF; i++) begin
            fe_data_i[i*32 +: 32]     = $urandom;
            fe_pred_npc_i[i*32 +: 32] = $urandom;
        end
    endtask

    // Advance the model with the rules applied to the current inputs, then run one clock cycle to the next falling edge.
    task automatic tick();
        int sz;
        bit rdy;
        entry_t e;
        sz  = q.size();
        rdy = (sz <= DEPTH - IPF);
        if (flush_i) begin
            q.delete();
        end else begin
            if (de_ready_i) begin
                for (int n = 0; n < ((sz < DW) ? sz : DW); n++) void'(q.pop_front());
            end
            if (fe_valid_i && rdy) begin
                for (int i = 0; i < IPF; i++) begin
                    if (fe_slot_valid_i[i]) begin
                        e.instr = fe_data_i[i*32 +: 32];
                        e.pc    = fe_pc_i + 32'(4 * i);
                        e.npc   = fe_pred_npc_i[i*32 +: 32];
                        q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compute the expected decode window from the model queue.
    function automatic logic [387:0] model_out();
        logic [3:0]   v;
        logic [127:0] ins, pcs, npcs;
        v = '0; ins = '0; pcs = '0; npcs = '0;
        for (int k = 0; k < DW; k++) begin
            if (k < q.size()) begin
                v[k] = 1'b1;
                ins[k*32 +: 32]  = q[k].instr;
                pcs[k*32 +: 32]  = q[k].pc;
                npcs[k*32 +: 32] = q[k].npc;
            end
        end
        return {v, ins, pcs, npcs};
    endfunction

    task automatic idle_inputs();
        flush_i = 1'b0; fe_valid_i = 1'b0; de_ready_i = 1'b0;
        set_group(32'h0, 4'b0000);
    endtask

    task automatic do_flush();
        idle_inputs();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", fe_ready_o);
        end
        checks++;
        if (de_valid_o !== 4'b0000) begin
            errors++; $display("FAIL reset_valid got %b exp 0000", de_valid_o);
        end
    endtask

    task automatic test_basic();
        idle_inputs();
        fe_valid_i = 1'b1;
        set_group(32'h8000_0000, 4'b1111);
        tick();
        fe_valid_i = 1'b0;
        checks++;
        if (de_valid_o !== 4'b1111) begin
            errors++; $display("FAIL basic_valid got %b exp 1111", de_valid_o);
        end
        checks++;
        if (de_pc_o !== {32'h8000_000C, 32'h8000_0008, 32'h8000_0004, 32'h8000_0000}) begin
            errors++; $display("FAIL basic_pc got %h", de_pc_o);
        end
        checks++;
        if ({de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o} !== model_out()) begin
            errors++; $display("FAIL basic_model got %h exp %h",
                {de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o}, model_out());
        end
        do_flush();
    endtask

    task automatic test_partial();
        logic [127:0] npc_in;
        idle_inputs();
        fe_valid_i = 1'b1;
        set_group(32'h100, 4'b0110);
        npc_in = fe_pred_npc_i;
        tick();
        fe_valid_i = 1'b0;
        checks++;
        if (de_valid_o !== 4'b0011) begin
            errors++; $display("FAIL partial_valid got %b exp 0011", de_valid_o);
        end
        checks++;
        if (de_pc_o[63:0] !== {32'h108, 32'h104}) begin
            errors++; $display("FAIL partial_pc got %h exp 0000010800000104", de_pc_o[63:0]);
        end
        checks++;
        if (de_pred_npc_o[63:0] !== npc_in[95:32]) begin
            errors++; $display("FAIL partial_npc got %h exp %h", de_pred_npc_o[63:0], npc_in[95:32]);
        end
        checks++;
        if (de_pc_o[127:64] !== 64'h0 || de_instr_o[127:64] !== 64'h0) begin
            errors++; $display("FAIL partial_zero got pc %h instr %h exp 0", de_pc_o[127:64], de_instr_o[127:64]);
        end
        do_flush();
    endtask

    task automatic test_full();
        logic [3:0] exp_rdy;
        exp_rdy = 4'b1111;
        idle_inputs();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (fe_ready_o !== exp_rdy[g]) begin
                errors++; $display("FAIL full_ready_g%0d got %b exp %b", g, fe_ready_o, exp_rdy[g]);
            end
            fe_valid_i = 1'b1;
            set_group(32'h2000 + 32'(16 * g), 4'b1111);
            tick();
        end
        checks++;
        if (fe_ready_o !== 1'b0) begin
            errors++; $display("FAIL full_ready_16 got %b exp 0", fe_ready_o);
        end
        // Hold a group while the buffer is full; it must not be accepted yet.
        set_group(32'h3000, 4'b0001);
        tick();
        checks++;
        if ({de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o} !== model_out() || q.size() != 16) begin
            errors++; $display("FAIL full_hold got %h exp %h",
                {de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o}, model_out());
        end
        fe_valid_i = 1'b0;
        de_ready_i = 1'b1;
        tick();
        de_ready_i = 1'b0;
        checks++;
        if (fe_ready_o !== 1'b1 || de_valid_o !== 4'b1111) begin
            errors++; $display("FAIL full_drain got ready %b valid %b exp 1 1111", fe_ready_o, de_valid_o);
        end
        checks++;
        if (de_pc_o[31:0] !== 32'h2010) begin
            errors++; $display("FAIL full_drain_pc got %h exp 00002010", de_pc_o[31:0]);
        end
        do_flush();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        fe_valid_i = 1'b1;
        set_group(32'h4000, 4'b1111);
        tick();
        set_group(32'h4010, 4'b0001);
        tick();
        set_group(32'h4020, 4'b0111);
        de_ready_i = 1'b1;
        tick();
        fe_valid_i = 1'b0; de_ready_i = 1'b0;
        checks++;
        if (de_valid_o !== 4'b1111 || de_pc_o !== {32'h4028, 32'h4024, 32'h4020, 32'h4010}) begin
            errors++; $display("FAIL simul got valid %b pc %h", de_valid_o, de_pc_o);
        end
        // One more pop leaves exactly 0 entries if the count is 4.
        de_ready_i = 1'b1;
        tick();
        de_ready_i = 1'b0;
        checks++;
        if (de_valid_o !== 4'b0000) begin
            errors++; $display("FAIL simul_count got %b exp 0000", de_valid_o);
        end
        do_flush();
    endtask

    task automatic test_random_wrap();
        logic [31:0] next_pc;
        logic [31:0] last_pc;
        bit          have_last;
        bit          accepted;
        next_pc = 32'h1_0000;
        have_last = 1'b0;
        idle_inputs();
        set_group(next_pc, 4'($urandom));
        for (int c = 0; c < 400; c++) begin
            fe_valid_i = ($urandom_range(0, 9) < 7);
            de_ready_i = $urandom_range(0, 1);
            checks++;
            if ({de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o} !== model_out()) begin
                errors++; $display("FAIL rand_out c%0d got %h exp %h", c,
                    {de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o}, model_out());
            end
            checks++;
            if (fe_ready_o !== (q.size() <= DEPTH - IPF)) begin
                errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, fe_ready_o, q.size() <= DEPTH - IPF);
            end
            if (de_ready_i) begin
                for (int k = 0; k < DW; k++) begin
                    if (de_valid_o[k]) begin
                        if (have_last) begin
                            checks++;
                            if (de_pc_o[k*32 +: 32] <= last_pc) begin
                                errors++; $display("FAIL rand_order c%0d got %h after %h", c, de_pc_o[k*32 +: 32], last_pc);
                            end
                        end
                        last_pc = de_pc_o[k*32 +: 32];
                        have_last = 1'b1;
                    end
                end
            end
            accepted = fe_valid_i && fe_ready_o;
            tick();
            if (accepted) begin
                next_pc = next_pc + 32'd16;
                set_group(next_pc, 4'($urandom));
            end
        end
        do_flush();
    endtask

    task automatic test_flush();
        idle_inputs();
        fe_valid_i = 1'b1;
        set_group(32'h5000, 4'b1111); tick();
        set_group(32'h5010, 4'b1111); tick();
        set_group(32'h5020, 4'b0001); tick();
        checks++;
        if (de_valid_o !== 4'b1111 || fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_pre got valid %b ready %b exp 1111 1", de_valid_o, fe_ready_o);
        end
        set_group(32'h6000, 4'b1111);
        flush_i = 1'b1; de_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; de_ready_i = 1'b0; fe_valid_i = 1'b0;
        checks++;
        if (de_valid_o !== 4'b0000 || fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_post got valid %b ready %b exp 0000 1", de_valid_o, fe_ready_o);
        end
        tick();
        checks++;
        if (de_valid_o !== 4'b0000) begin
            errors++; $display("FAIL flush_absent got %b exp 0000", de_valid_o);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        fe_valid_i = 1'b1;
        set_group(32'h7000, 4'b1111); tick();
        set_group(32'h7010, 4'b1111); tick();
        fe_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        q.delete();
        #1;
        checks++;
        if (de_valid_o !== 4'b0000 || fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL arst_immediate got valid %b ready %b exp 0000 1", de_valid_o, fe_ready_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        checks++;
        if (de_valid_o !== 4'b0000) begin
            errors++; $display("FAIL arst_stale got %b exp 0000", de_valid_o);
        end
        fe_valid_i = 1'b1;
        set_group(32'h9000, 4'b0011);
        tick();
        fe_valid_i = 1'b0;
        checks++;
        if ({de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o} !== model_out() || de_valid_o !== 4'b0011) begin
            errors++; $display("FAIL arst_new got %h exp %h",
                {de_valid_o, de_instr_o, de_pc_o, de_pred_npc_o}, model_out());
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_partial();
        test_full();
        test_simultaneous();
        test_random_wrap();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
